// File: rtl/test_addr_sequencer.sv
// test_addr_sequencer: issues a programmable range of operand-RAM read
// addresses over one or more passes and regenerates the matching result-RAM
// write strobe/address after a run-time latency taken from a fixed-depth
// delay line.
//
// Handshake: start is a one-cycle request, honoured only while idle (busy=0).
// It is ignored at all other times. abort is a level, honoured only while
// reads are being issued. The read presented in the abort cycle is still
// written back later.
module test_addr_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_LAT    = 15,
  parameter int CNT_WIDTH  = 32,
  localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_first,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  input  logic [LAT_W-1:0]      cfg_latency,
  input  logic [7:0]            cfg_passes,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pass_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic                    done_q, done_d;

  // Configuration captured when a run is accepted.
  logic [ADDR_WIDTH-1:0]   first_q, last_q;
  logic [7:0]              passes_q;
  logic [LAT_W-1:0]        lat_q;

  // Delay line: stage i holds the read issued i+1 cycles ago.
  logic [MAX_LAT-1:0]      dl_vld_q;
  logic [ADDR_WIDTH-1:0]   dl_addr_q [MAX_LAT];

  logic                    accept;
  logic                    tap_vld;
  logic [ADDR_WIDTH-1:0]   tap_addr;
  logic                    pending;
  logic                    final_read;

  assign accept = (state_q == S_IDLE) && start;

  // State and counter registers.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_cnt_q <= pass_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      done_q     <= done_d;
    end
  end

  // Latch the run configuration on acceptance; latency is clamped to the line depth.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      first_q  <= '0;
      last_q   <= '0;
      passes_q <= '0;
      lat_q    <= '0;
    end else if (accept) begin
      first_q  <= cfg_first;
      last_q   <= cfg_last;
      passes_q <= cfg_passes;
      lat_q    <= (cfg_latency > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : cfg_latency;
    end
  end

  // Shift reads down the delay line; a new run starts from an empty line so
  // leftovers of a previous run can never appear at a longer tap.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      dl_vld_q <= '0;
      for (int i = 0; i < MAX_LAT; i++) dl_addr_q[i] <= '0;
    end else if (accept) begin
      dl_vld_q <= '0;
    end else begin
      for (int i = MAX_LAT - 1; i > 0; i--) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_addr_q[i] <= dl_addr_q[i-1];
      end
      dl_vld_q[0]  <= rd_en;
      dl_addr_q[0] <= rd_addr;
    end
  end

  // Select the tap for the latched latency and detect reads still ahead of it.
  always_comb begin
    tap_vld  = 1'b0;
    tap_addr = '0;
    pending  = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (int'(lat_q) == i + 1) begin
        tap_vld  = dl_vld_q[i];
        tap_addr = dl_addr_q[i];
      end
      if ((i + 1) < int'(lat_q) && dl_vld_q[i]) pending = 1'b1;
    end
  end

  // Next-state logic: address stepping, pass counting, completion.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_cnt_d = pass_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    done_d     = done_q;
    final_read = 1'b0;

    // Cycle counter runs for every busy cycle and sticks at all-ones.
    if (state_q != S_IDLE && cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          addr_d     = cfg_first;
          pass_cnt_d = '0;
          cyc_cnt_d  = '0;
          done_d     = 1'b0;
        end
      end
      S_ISSUE: begin
        // Reading the last address completes a pass, even in an abort cycle.
        if (addr_q == last_q) pass_cnt_d = pass_cnt_q + 8'd1;
        if (abort) begin
          final_read = 1'b1;
        end else if (addr_q == last_q) begin
          if (passes_q == 8'd0 || (pass_cnt_q + 8'd1) != passes_q) addr_d = first_q;
          else final_read = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        // With zero latency the final write coincides with the final read.
        if (final_read) begin
          if (lat_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // No valid entry ahead of the tap: this cycle carries the final write.
        if (!pending) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en       = (state_q == S_ISSUE);
  assign rd_addr     = rd_en ? addr_q : '0;
  assign wr_en       = (lat_q == '0) ? rd_en : tap_vld;
  assign wr_addr     = (lat_q == '0) ? rd_addr : tap_addr;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign pass_count  = pass_cnt_q;
  assign cycle_count = cyc_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_test_addr_sequencer.sv
// Bench for test_addr_sequencer: drives runs, predicts every read and write
// (address and cycle) from the run parameters and checks them in a monitor.
module tb_test_addr_sequencer;

  localparam int ADDR_W  = 11;
  localparam int MAX_LAT = 12;
  localparam int CNT_W   = 8;
  localparam int LAT_W   = 4;
  localparam int AMOD    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_first = '0;
  logic [ADDR_W-1:0] cfg_last = '0;
  logic [LAT_W-1:0]  cfg_latency = '0;
  logic [7:0]        cfg_passes = '0;
  logic              rd_en, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]        pass_count;
  logic [CNT_W-1:0]  cycle_count;
  logic [1:0]        dbg_state;

  test_addr_sequencer #(
    .ADDR_WIDTH(ADDR_W), .MAX_LAT(MAX_LAT), .CNT_WIDTH(CNT_W)
  ) dut (
    .pll_clock(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_latency(cfg_latency),
    .cfg_passes(cfg_passes), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
    .pass_count(pass_count), .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_rd_q[$];
  int                exp_rd_cyc_q[$];
  logic [ADDR_W-1:0] exp_wr_q[$];
  int                exp_wr_cyc_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the expected entry whenever the DUT strobes a read or write.
  always @(negedge clk) begin
    if (resetn) begin
      if (busy) busy_cycles++;
      if (rd_en) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd: got read addr %0d at cycle %0d, expected none", rd_addr, cyc);
        end else begin
          chk("rd_addr", longint'(rd_addr), longint'(exp_rd_q.pop_front()));
          chk("rd_cycle", longint'(cyc), longint'(exp_rd_cyc_q.pop_front()));
        end
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: got write addr %0d at cycle %0d, expected none", wr_addr, cyc);
        end else begin
          chk("wr_addr", longint'(wr_addr), longint'(exp_wr_q.pop_front()));
          chk("wr_cycle", longint'(cyc), longint'(exp_wr_cyc_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One run. k_abort=0 means run to completion; otherwise abort is sampled at
  // the edge ending the k_abort-th read cycle. Called and returns at a negedge.
  task automatic do_run(input int f, input int l, input int p, input int lat,
                        input int k_abort, input bit disturb, input bit abort_at_start);
    int n, k, leff, t0, tdone, exp_cc;
    bit got;
    n    = ((l - f) % AMOD + AMOD) % AMOD + 1;
    k    = (k_abort > 0) ? k_abort : n * p;
    leff = (lat > MAX_LAT) ? MAX_LAT : lat;
    t0   = cyc;
    for (int j = 0; j < k; j++) begin
      exp_rd_q.push_back(ADDR_W'((f + (j % n)) % AMOD));
      exp_rd_cyc_q.push_back(t0 + 1 + j);
      exp_wr_q.push_back(ADDR_W'((f + (j % n)) % AMOD));
      exp_wr_cyc_q.push_back(t0 + 1 + j + leff);
    end
    cfg_first   = ADDR_W'(f);
    cfg_last    = ADDR_W'(l);
    cfg_passes  = 8'(p);
    cfg_latency = LAT_W'(lat);
    busy_cycles = 0;
    start = 1'b1;
    abort = abort_at_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("done_cleared", longint'(done), 0);
    got = 1'b0;
    tdone = -1;
    for (int c = 0; c < k + leff + 50 && !got; c++) begin
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        got = 1'b1;
        tdone = cyc;
        chk("busy_after_done", longint'(busy), 0);
      end else begin
        if (k_abort > 0 && cyc == t0 + k) abort = 1'b1;
        if (disturb && cyc == t0 + 2) begin
          start       = 1'b1;
          cfg_first   = ADDR_W'($urandom_range(0, AMOD - 1));
          cfg_last    = ADDR_W'($urandom_range(0, AMOD - 1));
          cfg_passes  = 8'($urandom_range(0, 255));
          cfg_latency = LAT_W'($urandom_range(0, 15));
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    exp_cc = (k + leff > 255) ? 255 : k + leff;
    chk("done_seen", longint'(got), 1);
    chk("done_cycle", longint'(tdone), longint'(t0 + k + leff + 1));
    chk("busy_cycles", longint'(busy_cycles), longint'(k + leff));
    chk("pass_count", longint'(pass_count), longint'((k / n) % 256));
    chk("cycle_count", longint'(cycle_count), longint'(exp_cc));
    chk("rd_left", longint'(exp_rd_q.size()), 0);
    chk("wr_left", longint'(exp_wr_q.size()), 0);
    exp_rd_q.delete(); exp_rd_cyc_q.delete();
    exp_wr_q.delete(); exp_wr_cyc_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, longint'(rd_en), 0);
    chk({tag, "_rd_addr"}, longint'(rd_addr), 0);
    chk({tag, "_wr_en"}, longint'(wr_en), 0);
    chk({tag, "_wr_addr"}, longint'(wr_addr), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_pass_count"}, longint'(pass_count), 0);
    chk({tag, "_cycle_count"}, longint'(cycle_count), 0);
  endtask

  // Reset with four reads issued and no write yet delivered (latency 6).
  task automatic reset_mid_run();
    int t0;
    t0 = cyc;
    for (int j = 0; j < 4; j++) begin
      exp_rd_q.push_back(ADDR_W'(100 + j));
      exp_rd_cyc_q.push_back(t0 + 1 + j);
    end
    cfg_first = 11'd100; cfg_last = 11'd120; cfg_passes = 8'd1; cfg_latency = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midrst");
    chk("midrst_rd_left", longint'(exp_rd_q.size()), 0);
    exp_rd_q.delete(); exp_rd_cyc_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_done_after", longint'(done), 0);
    chk("midrst_busy_after", longint'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f, span, p, lat, k, n;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    do_run(0, 3, 1, 5, 0, 0, 0);        // single pass
    do_run(2046, 1, 2, 2, 0, 0, 0);     // wrap range through 0
    do_run(10, 12, 0, 3, 8, 0, 0);      // continuous, abort after 8 reads
    do_run(5, 9, 2, 0, 0, 0, 0);        // zero latency
    do_run(40, 44, 1, 13, 0, 0, 0);     // latency clamp
    do_run(40, 42, 2, 15, 0, 0, 0);     // latency clamp, max encodable
    do_run(20, 30, 2, 4, 0, 1, 0);      // start + cfg change while busy
    do_run(10, 12, 3, 2, 3, 0, 0);      // abort on the last address of pass 1
    do_run(7, 7, 3, 1, 0, 0, 0);        // first==last, one read per pass
    do_run(300, 305, 1, 3, 0, 0, 1);    // start and abort together in idle
    do_run(0, 9, 0, 2, 300, 0, 0);      // cycle counter saturation
    reset_mid_run();
    do_run(500, 503, 1, 4, 0, 0, 0);    // normal run after reset

    for (int r = 0; r < 25; r++) begin
      f    = $urandom_range(0, AMOD - 1);
      span = $urandom_range(0, 12);
      p    = $urandom_range(0, 4);
      lat  = $urandom_range(0, 15);
      n    = span + 1;
      if (p == 0) k = $urandom_range(1, 3 * n + 2);
      else if ($urandom_range(0, 2) == 0) k = $urandom_range(1, n * p);
      else k = 0;
      do_run(f, (f + span) % AMOD, p, lat, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_addr_sequencer.md
# test_addr_sequencer

Parametrised address/enable sequencer for the arithmetic test harness, on the PLL clock domain. Replaces the fixed read-address generator and the fixed chain of address-delay stages. It issues a programmable range of operand-RAM read addresses over one or more passes. It regenerates the matching result-RAM write address and enable after a run-time-programmable pipeline latency, and reports completion, pass count and cycle count.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width.
- MAX_LAT, 15, largest supported read-to-write latency in cycles; LAT_W = $clog2(MAX_LAT+1).
- CNT_WIDTH, 32, cycle counter width.

Ports:
- pll_clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  stops issuing reads; sampled only in ISSUE.
- cfg_first  in  ADDR_WIDTH  first read address of each pass.
- cfg_last  in  ADDR_WIDTH  last read address of each pass.
- cfg_latency  in  LAT_W  read-to-write latency L; values above MAX_LAT are clamped to MAX_LAT.
- cfg_passes  in  8  number of passes; 0 means continuous until abort.
- rd_en  out  1  operand-RAM read strobe.
- rd_addr  out  ADDR_WIDTH  operand-RAM read address.
- wr_en  out  1  result-RAM write enable.
- wr_addr  out  ADDR_WIDTH  result-RAM write address.
- busy  out  1  run in progress.
- done  out  1  sticky completion flag.
- pass_count  out  8  completed passes; wraps modulo 256.
- cycle_count  out  CNT_WIDTH  cycles from the first rd_en to the final wr_en inclusive; saturates at all-ones.

## Operation
- Reset values: all outputs are 0, the delay line is empty, and the FSM is in IDLE.
- Delay line: MAX_LAT stages of {valid, addr}. The tap is selected by the latched L.
  - L=0: wr_en/wr_addr are combinationally equal to rd_en/rd_addr.
- FSM states:
  - IDLE: on start, latch all cfg_* inputs, clear pass_count, cycle_count and done, and go to ISSUE.
  - ISSUE: rd_en=1 each cycle and rd_addr advances by 1 modulo 2^ADDR_WIDTH. The first>last case wraps through 0.
  - Reads per pass = ((last-first) mod 2^ADDR_WIDTH)+1. first==last gives one read.
  - At rd_addr==last, pass_count increments. If passes remain, or the run is continuous, the next rd_addr is first; otherwise go to DRAIN.
  - abort sampled high in ISSUE: go to DRAIN. The read presented in that cycle is kept; no further reads are issued. A partial pass does not increment pass_count.
  - DRAIN: rd_en=0. Stay until the delay line holds no valid entry, then go to IDLE and set done.
- start outside IDLE is ignored. cfg_* changes after acceptance have no effect.
- start and abort in the same IDLE cycle: start is accepted and abort is ignored.
- cycle_count increments every cycle from the first rd_en through the final wr_en. It saturates and never wraps.
- Reset asserted mid-run: in-flight writes are discarded, outputs return to reset values immediately (asynchronously), and no done is produced.

## Timing
- start sampled at edge 0: busy=1 and rd_en=1 with rd_addr=cfg_first from cycle 1.
- The read issued in cycle n produces wr_en=1 with the same address in cycle n+L.
- Throughput is one read per cycle with no bubbles between passes.
- busy falls and done rises in the cycle after the final wr_en. done holds until the cycle after the next accepted start.
- An N-read, L-latency run: busy is high for N+L cycles and cycle_count ends at N+L.
- abort sampled at edge k: the last rd_en is in cycle k and the last wr_en is in cycle k+L.

## Test plan
- Single pass: first=0, last=3, passes=1, L=5, start at 0 -> rd_addr 0..3 in cycles 1-4; wr_addr 0..3 in cycles 6-9; done at 10; cycle_count=9; pass_count=1.
- Wrap range: ADDR_WIDTH=11, first=2046, last=1, passes=2, L=2 -> read sequence 2046,2047,0,1 repeated twice with no bubble; 8 writes delayed by 2; pass_count=2.
- Continuous plus abort: passes=0, first=10, last=12, L=3, abort at cycle 8 -> reads 10,11,12,10,11,12,10,11 then stop; last write in cycle 11; pass_count=2; done at 12.
- Latency 0 and clamp: with L=0, wr_en/wr_addr equal rd_en/rd_addr in the same cycle. With cfg_latency=MAX_LAT+1 (or larger), writes lag reads by MAX_LAT.
- Start while busy: a second start plus changed cfg during ISSUE -> no effect on the sequence, counts or done timing.
- Reset mid-run: resetn low during ISSUE with writes in flight -> all outputs 0 at once, no later wr_en, done=0; a subsequent start runs normally.
